// File: rtl/clk_stable_seq.sv
// ---------------------------------------------------------------------------
// clk_stable_seq
//
// Purpose:
//    Sequences the platform clock bring-up. After the clock-enable stage drops
//    the platform clocks OE#, a microsecond lock timer runs before the clocks
//    are declared stable. While stable, a second timer qualifies the CPU BCLK5
//    output. Losing the clocks while the main VR is still good is latched as a
//    sticky fault.
//
// Ports:
//    iClk          system clock, the only clock of the block
//    iRst_n        asynchronous active-low reset
//    i1uSCE        one-iClk-wide pulse every microsecond
//    iClksOe_n     platform clocks OE# (FM_PLD_CLKS_OE_N)
//    iBclk5Oe_n    CPU BCLK5 OE# (FM_CPU_BCLK5_OE_N)
//    iMainVRPwrgd  main VR power-good
//    iClrFault     single-cycle pulse clearing oClkFault
//    oClkStable    platform clocks settled
//    oBclk5Stable  BCLK5 settled (only ever set while oClkStable is set)
//    oClkFault     sticky flag for unexpected clock loss
//    oSeqState     current main FSM state encoding
//
// All inputs are already synchronous to iClk; no synchronizers are added.
// ---------------------------------------------------------------------------
module clk_stable_seq #(
   parameter logic [9:0] LOCK_US  = 10'd500,
   parameter logic [9:0] BCLK5_US = 10'd100
) (
   input  logic       iClk,
   input  logic       iRst_n,
   input  logic       i1uSCE,
   input  logic       iClksOe_n,
   input  logic       iBclk5Oe_n,
   input  logic       iMainVRPwrgd,
   input  logic       iClrFault,
   output logic       oClkStable,
   output logic       oBclk5Stable,
   output logic       oClkFault,
   output logic [1:0] oSeqState
);

   typedef enum logic [1:0] {
      IDLE      = 2'b00,
      WAIT_LOCK = 2'b01,
      STABLE    = 2'b10,
      ILLEGAL   = 2'b11
   } seqState_t;

   // A zero delay would never let the counters match, so it means one tick.
   localparam logic [9:0] LOCK_TGT  = (LOCK_US  == 10'd0) ? 10'd1 : LOCK_US;
   localparam logic [9:0] LOCK_LAST = LOCK_TGT - 10'd1;
   localparam logic [9:0] BCLK_TGT  = (BCLK5_US == 10'd0) ? 10'd1 : BCLK5_US;

   seqState_t  state_q;
   logic [9:0] lockCnt_q;
   logic       clkStable_q;
   logic [9:0] bclkCnt_q;
   logic [9:0] bclkCnt_d;
   logic       bclk5Stable_q;
   logic       bclk5Stable_d;
   logic       clkFault_q;
   logic       clkFault_d;
   logic       leaveStable;
   logic       bclkRun;

   // Leaving STABLE is decided from the current inputs so that the BCLK5
   // qualification drops on the same edge as oClkStable and can never outlive it.
   assign leaveStable = (state_q == STABLE) && iClksOe_n;
   assign bclkRun     = (state_q == STABLE) && !iClksOe_n && !iBclk5Oe_n;

   // Main sequencer: state, lock timer and registered oClkStable together.
   // The lock timer only advances on microsecond ticks and stops at the target
   // because the FSM leaves WAIT_LOCK on the final tick.
   always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) begin
         state_q     <= IDLE;
         lockCnt_q   <= 10'd0;
         clkStable_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               lockCnt_q   <= 10'd0;
               clkStable_q <= 1'b0;
               if (!iClksOe_n) begin
                  state_q <= WAIT_LOCK;
               end
            end
            WAIT_LOCK: begin
               if (iClksOe_n) begin
                  state_q     <= IDLE;
                  lockCnt_q   <= 10'd0;
                  clkStable_q <= 1'b0;
               end else if (i1uSCE) begin
                  lockCnt_q <= lockCnt_q + 10'd1;
                  if (lockCnt_q == LOCK_LAST) begin
                     state_q     <= STABLE;
                     clkStable_q <= 1'b1;
                  end
               end
            end
            STABLE: begin
               if (iClksOe_n) begin
                  state_q     <= IDLE;
                  lockCnt_q   <= 10'd0;
                  clkStable_q <= 1'b0;
               end else begin
                  clkStable_q <= 1'b1;
               end
            end
            default: begin
               state_q     <= IDLE;
               lockCnt_q   <= 10'd0;
               clkStable_q <= 1'b0;
            end
         endcase
      end
   end

   // Fault set wins over a simultaneous clear; an orderly power-down (VR
   // already gone) is not a fault.
   always_comb begin
      clkFault_d = clkFault_q;
      if (leaveStable && iMainVRPwrgd) begin
         clkFault_d = 1'b1;
      end else if (iClrFault) begin
         clkFault_d = 1'b0;
      end
   end

   // BCLK5 timer counts ticks only while qualified and saturates at the target.
   always_comb begin
      bclkCnt_d = 10'd0;
      if (bclkRun) begin
         bclkCnt_d = bclkCnt_q;
         if (i1uSCE && (bclkCnt_q != BCLK_TGT)) begin
            bclkCnt_d = bclkCnt_q + 10'd1;
         end
      end
      bclk5Stable_d = bclkRun && (bclkCnt_d == BCLK_TGT);
   end

   // Registers for the fault flag and the BCLK5 timer.
   always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) begin
         clkFault_q    <= 1'b0;
         bclkCnt_q     <= 10'd0;
         bclk5Stable_q <= 1'b0;
      end else begin
         clkFault_q    <= clkFault_d;
         bclkCnt_q     <= bclkCnt_d;
         bclk5Stable_q <= bclk5Stable_d;
      end
   end

   assign oClkStable   = clkStable_q;
   assign oBclk5Stable = bclk5Stable_q;
   assign oClkFault    = clkFault_q;
   assign oSeqState    = state_q;

endmodule

// File: tb/tb_clk_stable_seq.sv
// ---------------------------------------------------------------------------
// tb_clk_stable_seq
//
// Drives two instances from shared inputs: one with short delays (lock 5 us,
// BCLK5 3 us) and one with both delays set to zero, which must behave as one
// tick each. Outputs are compared as a packed {clk, bclk5, fault, state}.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_clk_stable_seq;

   logic       iClk;
   logic       iRst_n;
   logic       i1uSCE;
   logic       iClksOe_n;
   logic       iBclk5Oe_n;
   logic       iMainVRPwrgd;
   logic       iClrFault;
   logic       aClkStable, aBclk5Stable, aClkFault;
   logic [1:0] aSeqState;
   logic       zClkStable, zBclk5Stable, zClkFault;
   logic [1:0] zSeqState;

   int compared = 0;
   int mismatched = 0;

   typedef struct {
      bit oe; bit boe; bit tick; bit pg; bit clr;
      bit eClk; bit eB; bit eF; bit [1:0] eSt;
   } vec_t;

   vec_t vecs[$];

   typedef struct {
      int phase;
      int ticks;
      bit clk;
      int bticks;
      bit bst;
      bit fault;
   } model_t;

   localparam model_t MODEL_RESET = '{0, 0, 1'b0, 0, 1'b0, 1'b0};

   model_t mA;
   model_t mZ;

   clk_stable_seq #(.LOCK_US(10'd5), .BCLK5_US(10'd3)) dut (
      .iClk(iClk), .iRst_n(iRst_n), .i1uSCE(i1uSCE), .iClksOe_n(iClksOe_n),
      .iBclk5Oe_n(iBclk5Oe_n), .iMainVRPwrgd(iMainVRPwrgd), .iClrFault(iClrFault),
      .oClkStable(aClkStable), .oBclk5Stable(aBclk5Stable), .oClkFault(aClkFault),
      .oSeqState(aSeqState)
   );

   clk_stable_seq #(.LOCK_US(10'd0), .BCLK5_US(10'd0)) dutZero (
      .iClk(iClk), .iRst_n(iRst_n), .i1uSCE(i1uSCE), .iClksOe_n(iClksOe_n),
      .iBclk5Oe_n(iBclk5Oe_n), .iMainVRPwrgd(iMainVRPwrgd), .iClrFault(iClrFault),
      .oClkStable(zClkStable), .oBclk5Stable(zBclk5Stable), .oClkFault(zClkFault),
      .oSeqState(zSeqState)
   );

   initial iClk = 1'b0;
   always #5 iClk = ~iClk;

   // Behavioural view: phase 0 = clocks off, 1 = waiting for lock, 2 = locked.
   // Delays are counted in whole microsecond ticks, zero meaning one.
   function automatic model_t stepModel(model_t m, int lockUs, int bUs,
                                        bit oe, bit boe, bit tick, bit pg, bit clr);
      model_t n;
      int lockT;
      int bT;
      bit lost;
      n = m;
      lockT = (lockUs == 0) ? 1 : lockUs;
      bT = (bUs == 0) ? 1 : bUs;
      lost = (m.phase == 2) && oe;
      n.fault = (lost && pg) || (m.fault && !clr);
      if (m.phase == 2 && !oe && !boe) begin
         if (tick && m.bticks < bT) n.bticks = m.bticks + 1;
         n.bst = (n.bticks >= bT);
      end else begin
         n.bticks = 0;
         n.bst = 1'b0;
      end
      if (m.phase == 0) begin
         n.ticks = 0;
         if (!oe) n.phase = 1;
      end else if (m.phase == 1) begin
         if (oe) begin
            n.phase = 0;
            n.ticks = 0;
         end else if (tick) begin
            n.ticks = m.ticks + 1;
            if (n.ticks == lockT) n.phase = 2;
         end
      end else begin
         if (oe) begin
            n.phase = 0;
            n.ticks = 0;
         end
      end
      n.clk = (n.phase == 2);
      return n;
   endfunction

   // Reference models advance on the same edges as the instances.
   always @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) begin
         mA <= MODEL_RESET;
         mZ <= MODEL_RESET;
      end else begin
         mA <= stepModel(mA, 5, 3, iClksOe_n, iBclk5Oe_n, i1uSCE, iMainVRPwrgd, iClrFault);
         mZ <= stepModel(mZ, 0, 0, iClksOe_n, iBclk5Oe_n, i1uSCE, iMainVRPwrgd, iClrFault);
      end
   end

   function automatic logic [4:0] packModel(model_t m);
      return {m.clk, m.bst, m.fault, 2'(m.phase)};
   endfunction

   // Drive every data input in one call.
   task automatic applyStimulus(input bit oe, input bit boe, input bit tick,
                                input bit pg, input bit clr);
      iClksOe_n    = oe;
      iBclk5Oe_n   = boe;
      i1uSCE       = tick;
      iMainVRPwrgd = pg;
      iClrFault    = clr;
   endtask

   // Compare {clk, bclk5, fault, state} and report any difference.
   task automatic checkOutput(input string name, input logic [4:0] actual,
                              input logic [4:0] expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got clk=%b bclk5=%b fault=%b state=%b, expected clk=%b bclk5=%b fault=%b state=%b",
                  name, actual[4], actual[3], actual[2], actual[1:0],
                  expected[4], expected[3], expected[2], expected[1:0]);
      end
   endtask

   function automatic logic [4:0] outA();
      return {aClkStable, aBclk5Stable, aClkFault, aSeqState};
   endfunction

   function automatic logic [4:0] outZ();
      return {zClkStable, zBclk5Stable, zClkFault, zSeqState};
   endfunction

   function automatic void addVec(bit oe, bit boe, bit tick, bit pg, bit clr,
                                  bit eClk, bit eB, bit eF, bit [1:0] eSt);
      vec_t v;
      v = '{oe, boe, tick, pg, clr, eClk, eB, eF, eSt};
      vecs.push_back(v);
   endfunction

   task automatic doReset();
      applyStimulus(1, 1, 0, 1, 0);
      iRst_n = 1'b0;
      @(negedge iClk);
      @(negedge iClk);
      checkOutput("reset_state", outA(), 5'b000_00);
      iRst_n = 1'b1;
      @(negedge iClk);
   endtask

   task automatic clockOne(input bit oe, input bit boe, input bit tick,
                           input bit pg, input bit clr);
      applyStimulus(oe, boe, tick, pg, clr);
      @(negedge iClk);
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      iRst_n = 1'b0;
      applyStimulus(1, 1, 0, 1, 0);

      // Lock timing with a tick every 10 cycles.
      doReset();
      clockOne(0, 1, 0, 1, 0);
      checkOutput("lock_enter_wait", outA(), 5'b000_01);
      for (int k = 1; k <= 5; k++) begin
         repeat (9) clockOne(0, 1, 0, 1, 0);
         if (k == 5) checkOutput("lock_before_5th", outA(), 5'b000_01);
         clockOne(0, 1, 1, 1, 0);
         if (k < 5) checkOutput("lock_counting", outA(), 5'b000_01);
         else checkOutput("lock_after_5th", outA(), 5'b100_10);
      end

      // Zero-delay instance locks and qualifies BCLK5 after one tick each.
      doReset();
      clockOne(0, 1, 0, 1, 0);
      checkOutput("zero_wait", outZ(), 5'b000_01);
      clockOne(0, 1, 1, 1, 0);
      checkOutput("zero_lock_1tick", outZ(), 5'b100_10);
      checkOutput("zero_other_still_wait", outA(), 5'b000_01);
      clockOne(0, 0, 1, 1, 0);
      checkOutput("zero_bclk_1tick", outZ(), 5'b110_10);

      // Table-driven sequence on the 5/3 instance.
      vecs.delete();
      addVec(0,1,0,1,0, 0,0,0,2'b01);
      addVec(0,1,1,1,0, 0,0,0,2'b01);
      addVec(0,1,0,1,0, 0,0,0,2'b01);
      for (int i = 0; i < 3; i++) addVec(0,1,1,1,0, 0,0,0,2'b01);
      addVec(0,1,1,1,0, 1,0,0,2'b10);
      addVec(0,0,0,1,0, 1,0,0,2'b10);
      addVec(0,0,1,1,0, 1,0,0,2'b10);
      addVec(0,0,1,1,0, 1,0,0,2'b10);
      addVec(0,0,1,1,0, 1,1,0,2'b10);
      addVec(0,0,1,1,0, 1,1,0,2'b10);
      addVec(0,1,0,1,0, 1,0,0,2'b10);
      addVec(0,0,1,1,0, 1,0,0,2'b10);
      addVec(0,0,1,1,0, 1,0,0,2'b10);
      addVec(0,0,1,1,0, 1,1,0,2'b10);
      addVec(1,0,0,1,0, 0,0,1,2'b00);
      addVec(1,1,0,1,0, 0,0,1,2'b00);
      addVec(1,1,0,1,1, 0,0,0,2'b00);
      addVec(0,1,0,1,0, 0,0,0,2'b01);
      for (int i = 0; i < 4; i++) addVec(0,1,1,1,0, 0,0,0,2'b01);
      addVec(1,1,1,1,0, 0,0,0,2'b00);
      addVec(0,1,0,1,0, 0,0,0,2'b01);
      for (int i = 0; i < 4; i++) addVec(0,1,1,1,0, 0,0,0,2'b01);
      addVec(0,1,1,1,0, 1,0,0,2'b10);
      addVec(0,1,0,0,0, 1,0,0,2'b10);
      addVec(1,1,0,0,0, 0,0,0,2'b00);
      addVec(0,1,0,1,0, 0,0,0,2'b01);
      for (int i = 0; i < 4; i++) addVec(0,1,1,1,0, 0,0,0,2'b01);
      addVec(0,1,1,1,0, 1,0,0,2'b10);
      addVec(1,1,0,1,1, 0,0,1,2'b00);
      addVec(1,1,0,1,0, 0,0,1,2'b00);
      addVec(1,1,0,1,1, 0,0,0,2'b00);
      doReset();
      foreach (vecs[i]) begin
         clockOne(vecs[i].oe, vecs[i].boe, vecs[i].tick, vecs[i].pg, vecs[i].clr);
         checkOutput($sformatf("vec%0d", i), outA(),
                     {vecs[i].eClk, vecs[i].eB, vecs[i].eF, vecs[i].eSt});
      end

      // Reset in the middle of STABLE, then a full relock.
      doReset();
      clockOne(0, 1, 0, 1, 0);
      repeat (5) clockOne(0, 1, 1, 1, 0);
      repeat (3) clockOne(0, 0, 1, 1, 0);
      checkOutput("pre_reset_stable", outA(), 5'b110_10);
      #2;
      iRst_n = 1'b0;
      #1;
      checkOutput("async_reset", outA(), 5'b000_00);
      checkOutput("async_reset_zero", outZ(), 5'b000_00);
      @(negedge iClk);
      iRst_n = 1'b1;
      clockOne(0, 0, 0, 1, 0);
      checkOutput("relock_wait", outA(), 5'b000_01);
      repeat (4) clockOne(0, 0, 1, 1, 0);
      checkOutput("relock_4_ticks", outA(), 5'b000_01);
      clockOne(0, 0, 1, 1, 0);
      checkOutput("relock_5_ticks", outA(), 5'b100_10);

      // Randomized traffic against the reference models.
      doReset();
      applyStimulus(1, 1, 0, 1, 0);
      for (int i = 0; i < 3000; i++) begin
         checkOutput("rand_a", outA(), packModel(mA));
         checkOutput("rand_zero", outZ(), packModel(mZ));
         i1uSCE = ($urandom_range(0, 3) == 0);
         if ($urandom_range(0, 39) == 0) iClksOe_n = ~iClksOe_n;
         if ($urandom_range(0, 9) == 0) iBclk5Oe_n = ~iBclk5Oe_n;
         if ($urandom_range(0, 29) == 0) iMainVRPwrgd = ~iMainVRPwrgd;
         iClrFault = ($urandom_range(0, 19) == 0);
         iRst_n = ($urandom_range(0, 299) != 0);
         @(negedge iClk);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/clk_stable_seq.md
CLK_STABLE_SEQ -- requirements
Module: clk_stable_seq

Interface
REQ-001 Parameter LOCK_US, default 10'd500, meaning: microseconds from clock OE# assertion to oClkStable; a value of 0 is treated as 1.
REQ-002 Parameter BCLK5_US, default 10'd100, meaning: microseconds from BCLK5 OE# assertion (while stable) to oBclk5Stable; a value of 0 is treated as 1.
REQ-003 iClk  input  1  system clock; the single clock of the block.
REQ-004 iRst_n  input  1  reset, asynchronous, active-low.
REQ-005 i1uSCE  input  1  one-iClk-wide pulse every 1 us.
REQ-006 iClksOe_n  input  1  platform clocks OE#, driven by the clock-enable stage (FM_PLD_CLKS_OE_N).
REQ-007 iBclk5Oe_n  input  1  CPU BCLK5 OE# from the same stage (FM_CPU_BCLK5_OE_N).
REQ-008 iMainVRPwrgd  input  1  main VR power-good.
REQ-009 iClrFault  input  1  single-cycle pulse that clears oClkFault.
REQ-010 oClkStable  output  1  platform clocks settled; gates downstream resets.
REQ-011 oBclk5Stable  output  1  BCLK5 settled.
REQ-012 oClkFault  output  1  sticky flag for unexpected clock loss.
REQ-013 oSeqState  output  2  current main FSM state encoding.

Function
REQ-014 All inputs are synchronous to iClk; the block shall add no synchronizers.
REQ-015 All outputs shall be registered.
REQ-016 The main FSM shall have three states:
  - IDLE = 2'b00
  - WAIT_LOCK = 2'b01
  - STABLE = 2'b10
  - 2'b11 is illegal and shall recover to IDLE on the next clock.
REQ-017 IDLE: the lock counter (10 bit) shall be held at 0, and oClkStable = 0; iClksOe_n = 0 shall move the FSM to WAIT_LOCK on the next edge.
REQ-018 WAIT_LOCK: the lock counter shall increment by 1 on each cycle with i1uSCE = 1 and hold otherwise.
REQ-019 WAIT_LOCK: on the cycle where i1uSCE = 1 and counter = LOCK_US-1, the FSM shall move to STABLE, and oClkStable shall be 1 from the following cycle.
REQ-020 WAIT_LOCK: iClksOe_n = 1 shall return the FSM to IDLE with the counter cleared and no fault; this takes priority over a simultaneous i1uSCE.
REQ-021 STABLE: oClkStable = 1; iClksOe_n = 1 shall move the FSM to IDLE and drive oClkStable = 0 one cycle after iClksOe_n rises.
REQ-022 If iClksOe_n rises while in STABLE with iMainVRPwrgd = 1, oClkFault shall be set; with iMainVRPwrgd = 0 (orderly power-down) it shall not be set.
REQ-023 oClkFault shall remain set until an iClrFault pulse clears it; if set and clear occur in the same cycle, set wins.
REQ-024 BCLK5 sub-timer: a 10-bit counter shall run only while the main FSM is in STABLE and iBclk5Oe_n = 0, counting i1uSCE pulses.
REQ-025 BCLK5 sub-timer: oBclk5Stable shall go to 1 the cycle after the BCLK5_US-th pulse and saturate there.
REQ-026 oBclk5Stable and the BCLK5 counter shall clear on the next edge when iBclk5Oe_n = 1 or when the main FSM is not in STABLE.
REQ-027 oBclk5Stable = 1 shall imply oClkStable = 1 in every cycle.
REQ-028 Counters shall never wrap; after reaching their target they shall hold.
REQ-029 iClrFault shall not affect the FSM or the counters.

Reset
REQ-030 While iRst_n = 0, the block shall asynchronously force: FSM = IDLE, both counters = 0, oClkStable = 0, oBclk5Stable = 0, oClkFault = 0, oSeqState = 2'b00.
REQ-031 Reset asserted mid-WAIT_LOCK or mid-STABLE shall take effect immediately with no fault flagged.
REQ-032 After release, the FSM shall restart from IDLE and sample inputs on the first iClk edge.

Verification
REQ-033 Bench shall cover each of the following directed scenarios:
  - Lock timing: LOCK_US = 5, iClksOe_n 1->0, i1uSCE every 10 cycles -> oSeqState 01; oClkStable = 1 exactly one cycle after the 5th tick; oSeqState = 10.
  - Abort in WAIT_LOCK: iClksOe_n = 1 on the same cycle as the 5th tick -> oClkStable stays 0, FSM = IDLE, oClkFault = 0.
  - BCLK5 lock and drop: STABLE, iBclk5Oe_n = 0, BCLK5_US = 3 -> oBclk5Stable = 1 after the 3rd tick; iClksOe_n = 1 -> oClkStable and oBclk5Stable both 0 one cycle later.
  - Fault behaviour:
      - iClksOe_n rises in STABLE with iMainVRPwrgd = 1 -> oClkFault = 1 and holds.
      - iClrFault together with a new set condition -> oClkFault stays 1.
      - iClrFault alone -> oClkFault = 0 the next cycle.
  - Orderly power-down: iMainVRPwrgd = 0 followed by iClksOe_n = 1 -> oClkFault stays 0.
  - Mid-operation reset: iRst_n pulsed low during STABLE -> all outputs 0 asynchronously; a relock takes the full LOCK_US.
  - Zero parameter: LOCK_US = 0 -> lock occurs after exactly 1 tick.
